// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// word geometry and state-decode helpers.
package imem_loader_pkg;

  localparam int XLEN           = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int STATE_W        = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_CHK    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  // States in which a stream byte may be consumed.
  function automatic logic state_accepts_byte(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

  // A session is active everywhere except the three resting states.
  function automatic logic state_in_session(input state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = byte source / memory side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  import imem_loader_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into one little-endian word: each byte enters
// the top lane and older bytes move down, so the first byte ends in [7:0].
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_byte_en,
  input  logic [7:0]      i_byte,
  output logic            o_last_byte,
  output logic            o_word_valid,
  output logic [XLEN-1:0] o_word
);

  logic [1:0] r_cnt;
  logic       r_word_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
    end else if (i_clear) begin
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
    end else if (i_byte_en) begin
      r_cnt <= r_cnt + 2'd1;
      if (o_last_byte) begin
        r_word_valid <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] r_byte;
      if (gi == BYTES_PER_WORD - 1) begin : g_top
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_byte <= '0;
          end else if (i_byte_en) begin
            r_byte <= i_byte;
          end
        end
      end else begin : g_mid
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_byte <= '0;
          end else if (i_byte_en) begin
            r_byte <= g_lane[gi+1].r_byte;
          end
        end
      end
      assign o_word[8*gi +: 8] = r_byte;
    end
  endgenerate

  assign o_last_byte  = (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: header count, data words, one write per
// word, core held in reset until done. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_rst_n,
  output logic         busy,
  output logic         done,
  output logic         error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_TAIL = ST_CHK;
`else
  localparam logic [2:0] ST_TAIL = ST_DONE;
`endif

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [7:0]        r_count_lo;
  logic [15:0]       r_count;
  logic [ADDR_W:0]   r_index;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;

  logic              w_accept;
  logic              w_session_start;
  logic [15:0]       w_count;
  logic [ADDR_W:0]   w_index_inc;
  logic              w_last_word;
  logic              w_too_long;
  logic              w_last_byte;
  logic              w_word_valid;
  logic [XLEN-1:0]   w_word;

  assign w_accept        = bus.rx_valid && bus.rx_ready;
  assign w_session_start = start && !state_in_session(r_state);
  assign w_count         = {bus.rx_data, r_count_lo};
  assign w_index_inc     = r_index + 1'b1;
  assign w_last_word     = (17'(w_index_inc) == 17'(r_count));
  // Capacity check is done one bit wider so N = 2**ADDR_W itself stays legal.
  assign w_too_long      = (17'(w_count) > (17'd1 << ADDR_W));

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_session_start || (r_state == ST_WRITE)),
    .i_byte_en    (w_accept && (r_state == ST_DATA)),
    .i_byte       (bus.rx_data),
    .o_last_byte  (w_last_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_xsum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xsum <= '0;
    end else if (w_session_start) begin
      r_xsum <= '0;
    end else if (w_accept && (r_state == ST_DATA)) begin
      r_xsum <= r_xsum ^ bus.rx_data;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_accept) w_state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_accept) begin
          if (w_count == 16'd0)  w_state_next = ST_TAIL;
          else if (w_too_long)   w_state_next = ST_ERR;
          else                   w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_accept && w_last_byte) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_state_next = w_last_word ? ST_TAIL : ST_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_accept) w_state_next = (bus.rx_data == r_xsum) ? ST_DONE : ST_ERR;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count_lo <= '0;
      r_count    <= '0;
      r_index    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_session_start) begin
        r_index <= '0;
      end
      if (w_accept && (r_state == ST_LEN_LO)) begin
        r_count_lo <= bus.rx_data;
      end
      if (w_accept && (r_state == ST_LEN_HI)) begin
        r_count <= w_count;
      end
      if (r_state == ST_WRITE) begin
        r_index <= w_index_inc;
        r_addr  <= r_index[ADDR_W-1:0];
        r_wdata <= w_word;
      end
    end
  end

  // Address and data are live during WRITE and hold the last write afterwards.
  assign bus.imem_we    = (r_state == ST_WRITE) && w_word_valid;
  assign bus.imem_addr  = (r_state == ST_WRITE) ? r_index[ADDR_W-1:0] : r_addr;
  assign bus.imem_wdata = (r_state == ST_WRITE) ? w_word : r_wdata;
  assign bus.rx_ready   = state_accepts_byte(r_state);

  assign done       = (r_state == ST_DONE);
  assign error      = (r_state == ST_ERR);
  assign core_rst_n = (r_state == ST_DONE);
  assign busy       = state_in_session(r_state);

  a_no_ready_in_write : assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_we |-> !bus.rx_ready);
  a_index_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_we |-> !r_index[ADDR_W]);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued by the stimulus
// and popped by an independent write monitor.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_rst_n, busy, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_vec    = 0;
  int         n_miss   = 0;
  int         n_writes = 0;
  logic [7:0] xsum     = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Write monitor: every imem_we pulse must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.imem_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: addr %0d data %h, no write expected", bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("wr_data", bus.imem_wdata, e.data);
        check("wr_rx_ready_low", 32'(bus.rx_ready), 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      start        = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    t   = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_miss++;
      $display("FAIL rx_ready_timeout: rx_ready stayed 0, expected 1 within 50 cycles");
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_header(input int n);
    xsum = 8'h00;
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int a, input int max_gap);
    wr_t e;
    e.addr = a[ADDR_W-1:0];
    e.data = w;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], max_gap);
      xsum = xsum ^ w[8*k +: 8];
    end
  endtask

  task automatic finish_stream();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xsum, 0);
`endif
  endtask

  task automatic wait_end(input string name, input bit want_done, input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      t++;
    end while (!(done || error) && t < budget);
    check({name, ".done"},       32'(done),       32'(want_done));
    check({name, ".error"},      32'(error),      32'(!want_done));
    check({name, ".core_rst_n"}, 32'(core_rst_n), 32'(want_done));
    check({name, ".busy"},       32'(busy),       32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".rx_ready"},   32'(bus.rx_ready), 32'd0);
    check({name, ".imem_we"},    32'(bus.imem_we),  32'd0);
    check({name, ".imem_addr"},  32'(bus.imem_addr), 32'd0);
    check({name, ".imem_wdata"}, bus.imem_wdata,     32'd0);
    check({name, ".busy"},       32'(busy),       32'd0);
    check({name, ".done"},       32'(done),       32'd0);
    check({name, ".error"},      32'(error),      32'd0);
    check({name, ".core_rst_n"}, 32'(core_rst_n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    logic [31:0] word;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    idle(2);
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // N=2 with rx_valid held high throughout
    pulse_start();
    send_header(2);
    send_word(32'h00A00513, 0, 0);
    send_word(32'hFFF00593, 1, 0);
    finish_stream();
    wait_end("n2", 1'b1, 10);
    check("n2.addr_hold",  32'(bus.imem_addr), 32'd1);
    check("n2.wdata_hold", bus.imem_wdata,     32'hFFF00593);
    check("n2.we_idle",    32'(bus.imem_we),   32'd0);

    // start from DONE: done drops and core goes back into reset
    pulse_start();
    check("restart.done",       32'(done),         32'd0);
    check("restart.core_rst_n", 32'(core_rst_n),   32'd0);
    check("restart.busy",       32'(busy),         32'd1);
    check("restart.rx_ready",   32'(bus.rx_ready), 32'd1);

    // N=0: straight to completion, no write
    send_header(0);
    finish_stream();
    wait_end("n0", 1'b1, 2);

    // N=65 exceeds capacity
    pulse_start();
    send_header(65);
    wait_end("n65", 1'b0, 3);
    check("n65.rx_ready", 32'(bus.rx_ready), 32'd0);

    // N=64 with random valid gaps and a start pulse mid-session
    pulse_start();
    check("err_clear.error", 32'(error), 32'd0);
    send_header(64);
    w0 = n_writes;
    for (int i = 0; i < 64; i++) begin
      word = 32'h00000013 | (32'(i) << 20) | (32'(i % 32) << 7);
      if (i == 20) begin
        pulse_start();
        check("busy_start.busy", 32'(busy), 32'd1);
      end
      send_word(word, i, 2);
    end
    finish_stream();
    wait_end("n64", 1'b1, 20);
    check("n64.write_count", 32'(n_writes - w0), 32'd64);
    check("n64.queue_empty", 32'(exp_q.size()),  32'd0);
    check("n64.addr_hold",   32'(bus.imem_addr), 32'd63);

    // Reset pulse after two data bytes of word 0
    pulse_start();
    send_header(1);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check_reset_outputs("abort");
    idle(1);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    send_header(1);
    send_word(32'h00A00513, 0, 1);
    finish_stream();
    wait_end("reload", 1'b1, 10);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_header(1);
    send_word(32'h00A00513, 0, 0);
    send_byte(8'hB6, 0);
    wait_end("chk_ok", 1'b1, 5);

    pulse_start();
    send_header(1);
    send_word(32'h00A00513, 0, 0);
    send_byte(8'hB7, 0);
    wait_end("chk_bad", 1'b0, 5);

    pulse_start();
    check("chk_restart.error", 32'(error), 32'd0);
    check("chk_restart.busy",  32'(busy),  32'd1);
    send_header(1);
    send_word(32'h00A00513, 0, 0);
    send_byte(8'hB6, 0);
    wait_end("chk_again", 1'b1, 5);
`endif

    idle(3);
    check("final.queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
